// File: rtl/mem_lsu.sv
// Load/store unit between an RV32I core and a word-wide synchronous memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero-extended.
module mem_lsu #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_mem_rw,
    input  logic [31:0]       i_mem_data
);

    typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          off_q, off_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_data_q, mem_data_d;

    logic                req_bad;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    // Request decode: illegal size code or an address not aligned to the access size.
    always_comb begin
        req_bad = 1'b0;
        case (i_funct3)
            3'd0:       req_bad = 1'b0;
            3'd1:       req_bad = i_addr[0];
            3'd2:       req_bad = |i_addr[1:0];
            3'd4:       req_bad = i_we;
            3'd5:       req_bad = i_we | i_addr[0];
            default:    req_bad = 1'b1;
        endcase
    end

    always_comb begin
        byte_lane = i_mem_data[{off_q, 3'b000} +: 8];
        half_lane = i_mem_data[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'd1:    load_ext = {{16{half_lane[15]}}, half_lane};
            3'd4:    load_ext = {24'h0, byte_lane};
            3'd5:    load_ext = {16'h0, half_lane};
            default: load_ext = i_mem_data;
        endcase
        merged = i_mem_data;
        if (funct3_q[1:0] == 2'd0) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        // NOTE: every _d starts from a default so no path leaves it unassigned (no latches).
        state_d    = state_q;
        off_d      = off_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (req_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        off_d      = i_addr[1:0];
                        we_d       = i_we;
                        funct3_d   = i_funct3;
                        wdata_d    = i_wdata;
                        mem_addr_d = {i_addr[ADDR_W-1:2], 2'b00};
                        if (i_we && i_funct3 == 3'd2) begin
                            mem_data_d = i_wdata;
                            state_d    = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                if (we_q) begin
                    mem_data_d = merged;
                    state_d    = WRITE;
                end else begin
                    rdata_d = load_ext;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_rst_n) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            mem_addr_q <= '0;
            mem_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_rdata    = rdata_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    // Gated by reset so a reset landing in WRITE never reaches the memory.
    assign o_mem_rw   = (state_q == WRITE) && i_rst_n;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 7: width of the memory-side byte address; memory words are 32-bit at byte addresses with bits [1:0]=00.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 i_rst_n  input  1  synchronous active-low reset.
REQ-005 i_req  input  1  core access request, sampled only in IDLE.
REQ-006 i_we  input  1  1=store, 0=load.
REQ-007 i_addr  input  32  byte address; only bits [ADDR_W-1:0] used, upper bits ignored (wrap).
REQ-008 i_funct3  input  3  RV32I size code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-009 i_wdata  input  32  store data, right-aligned.
REQ-010 o_busy  output  1  high whenever state is not IDLE.
REQ-011 o_done  output  1  one-cycle completion pulse.
REQ-012 o_err  output  1  valid with o_done; misaligned or illegal funct3.
REQ-013 o_rdata  output  32  load result, sign/zero-extended, held until next load completes.
REQ-014 o_mem_addr  output  ADDR_W  word-aligned address to memory, bits [1:0] always 0.
REQ-015 o_mem_data  output  32  write data to memory.
REQ-016 o_mem_rw  output  1  0=read, 1=write.
REQ-017 i_mem_data  input  32  memory read data, valid the cycle after address is presented with o_mem_rw=0.

Function
REQ-018 States: IDLE, READ, CAPT, WRITE; request fields (addr, we, funct3, wdata) registered on acceptance.
REQ-019 IDLE + i_req: illegal funct3 (load 3/6/7, store 3-7) or misaligned (size half with addr[0]=1; word with addr[1:0]!=0) -> stay IDLE, o_done=1 and o_err=1 next cycle, no memory write, o_rdata unchanged.
REQ-020 IDLE + i_req legal: SW -> WRITE; all loads, SB, SH -> READ.
REQ-021 READ -> CAPT unconditionally; o_mem_rw=0, o_mem_addr=registered word address.
REQ-022 CAPT, load: register extracted lane into o_rdata (little-endian, byte lane addr[1:0], half lane addr[1]); sign-extend for funct3 0/1, zero-extend for 4/5; pulse o_done next cycle; -> IDLE.
REQ-023 CAPT, SB/SH: merge i_wdata low byte/half into i_mem_data at the addressed lane, other lanes preserved; register into o_mem_data; -> WRITE.
REQ-024 WRITE: o_mem_rw=1 for exactly one cycle; SW drives i_wdata unmodified; -> IDLE with o_done=1 (o_err=0) next cycle.
REQ-025 Latency (request-sample edge = E0): error done in cycle 1; SW done in cycle 2; loads done in cycle 3; SB/SH done in cycle 4.
REQ-026 i_req while o_busy=1 is ignored, not queued; i_req in the o_done cycle (IDLE) is accepted.
REQ-027 o_mem_rw shall be 0 in every state except WRITE; o_mem_rw = (state==WRITE) AND i_rst_n, so a reset asserted during WRITE suppresses the write.
REQ-028 o_mem_addr constant across READ, CAPT, WRITE of one transaction.

Reset
REQ-029 i_rst_n=0 at a rising edge: state=IDLE, o_done=0, o_err=0, o_rdata=0, o_mem_addr=0, o_mem_data=0, o_busy=0.
REQ-030 Reset mid-transaction aborts it with no o_done pulse and no memory write.

Verification
REQ-031 Memory word 0x0C=0x8899AABB; LB addr 0x0D -> o_rdata=0xFFFFFFAA, o_done in cycle 3, o_err=0.
REQ-032 Same word; LHU addr 0x0E -> o_rdata=0x00008899; LW addr 0x0C -> 0x8899AABB.
REQ-033 SB addr 0x0F, i_wdata=0x00000012 -> one write cycle, word 0x0C becomes 0x1299AABB, o_done in cycle 4.
REQ-034 SW addr 0x11 -> o_done=1, o_err=1 in cycle 1, o_mem_rw never 1, memory unchanged; LW with i_funct3=3 -> same error response.
REQ-035 SH addr 0x0C, i_rst_n=0 during WRITE cycle -> o_mem_rw=0, word unchanged, no o_done, IDLE after edge.
REQ-036 i_req held high for 10 cycles with LW -> transactions back-to-back, one o_done per 3 cycles, no request accepted while o_busy=1.
